// File: rtl/enc_src_arbiter.sv
// Round-robin message-level arbiter feeding one encoder. A granted requester owns
// the encoder for a full message of ARB_MES_BEATS beats, or until it idles too long.
module enc_src_arbiter #(
  parameter int ARB_REQ       = 4,
  parameter int EGF_DIM       = 8,
  parameter int ENC_SYM       = 4,
  parameter int ARB_MES_BEATS = 56,
  parameter int ARB_TIMEOUT   = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ARB_REQ-1:0]                   req_valid,
  input  logic [ARB_REQ*ENC_SYM*EGF_DIM-1:0]   req_data,
  output logic [ARB_REQ-1:0]                   req_ready,
  input  logic                                 con_stall,
  output logic [ENC_SYM*EGF_DIM-1:0]           gen_data,
  output logic                                 gen_valid,
  output logic                                 arb_sof,
  output logic                                 arb_eof,
  output logic [$clog2(ARB_REQ)-1:0]           arb_owner,
  output logic                                 arb_busy,
  output logic                                 arb_err
);

  localparam int BEAT_W = ENC_SYM * EGF_DIM;
  localparam int OW     = $clog2(ARB_REQ);
  localparam int CW     = (ARB_MES_BEATS > 1) ? $clog2(ARB_MES_BEATS) : 1;
  localparam int TW     = $clog2(ARB_TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(ARB_MES_BEATS - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(ARB_TIMEOUT);
  localparam logic [OW-1:0] LAST_REQ  = OW'(ARB_REQ - 1);

  logic [0:0]        state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     to_q, to_d;
  logic [BEAT_W-1:0] gen_data_q, gen_data_d;
  logic              gen_valid_q, gen_valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              err_q, err_d;

  logic              owner_valid_s;
  logic              accept_s;
  logic              idle_tick_s;
  logic              timeout_s;
  logic [TW-1:0]     to_inc_s;
  logic [OW:0]       pick_s;

  // Index wrap that stays inside 0..ARB_REQ-1 even when ARB_REQ is not a power of two.
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
    if (idx == LAST_REQ) begin
      return '0;
    end else begin
      return idx + OW'(1);
    end
  endfunction

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [OW:0] rr_pick(input logic [ARB_REQ-1:0] valid,
                                          input logic [OW-1:0]      ptr);
    logic [OW:0]   pick;
    logic [OW-1:0] idx;
    pick = '0;
    idx  = ptr;
    for (int k = 0; k < ARB_REQ; k++) begin
      if (!pick[OW] && valid[idx]) begin
        pick = {1'b1, idx};
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  assign pick_s        = rr_pick(req_valid, ptr_q);
  assign owner_valid_s = req_valid[owner_q];
  assign accept_s      = (state_q == ST_XFER) && owner_valid_s && !con_stall;
  assign idle_tick_s   = (state_q == ST_XFER) && !owner_valid_s && !con_stall;
  assign to_inc_s      = to_q + TW'(1);
  assign timeout_s     = idle_tick_s && (to_inc_s == TO_LIMIT);

  // Only the owner sees ready, and only when the encoder is consuming.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_XFER) && !con_stall) begin
      req_ready[owner_q] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    to_d        = to_q;
    gen_valid_d = 1'b0;
    gen_data_d  = '0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[OW]) begin
          owner_d = pick_s[OW-1:0];
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s) begin
          gen_valid_d = 1'b1;
          gen_data_d  = req_data[int'(owner_q)*BEAT_W +: BEAT_W];
          sof_d       = (beat_q == '0);
          eof_d       = (beat_q == LAST_BEAT);
          to_d        = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            ptr_d   = wrap_inc(owner_q);
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end else if (timeout_s) begin
          // Abandon the message: no eof, owner loses its turn.
          err_d   = 1'b1;
          state_d = ST_IDLE;
          beat_d  = '0;
          to_d    = '0;
          ptr_d   = wrap_inc(owner_q);
        end else if (idle_tick_s) begin
          to_d = to_inc_s;
        end else begin
          to_d = to_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_q      <= '0;
      to_q        <= '0;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      to_q        <= to_d;
      gen_data_q  <= gen_data_d;
      gen_valid_q <= gen_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
    end
  end

  assign gen_data  = gen_data_q;
  assign gen_valid = gen_valid_q;
  assign arb_sof   = sof_q;
  assign arb_eof   = eof_q;
  assign arb_owner = owner_q;
  assign arb_busy  = (state_q == ST_XFER);
  assign arb_err   = err_q;

endmodule

// File: tb/tb_enc_src_arbiter.sv
// Bench for enc_src_arbiter: a 4-requester and a 3-requester instance, each checked
// every cycle against a message-level reference model, plus directed scenarios.
module tb_enc_src_arbiter;

  localparam int MB = 56;
  localparam int TO = 255;

  typedef struct packed {
    int          n;
    bit          busy;
    int          owner;
    int          ptr;
    int          beats;
    int          idle;
    bit          gv;
    logic [31:0] gd;
    bit          sof;
    bit          eof;
    bit          err;
  } model_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] d;
    bit          sof;
    bit          eof;
  } beat_t;

  typedef struct packed {
    logic [3:0] v;
    bit         s;
    logic [3:0] rdy;
    bit         gv;
    bit         sof;
    bit         busy;
    logic [1:0] own;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic stall = 1'b0;

  logic [3:0]   v4 = '0;
  logic [127:0] d4 = '0;
  logic [3:0]   rdy4;
  logic [31:0]  gd4;
  logic         gv4, sof4, eof4, busy4, err4;
  logic [1:0]   own4;

  logic [2:0]   v3 = '0;
  logic [95:0]  d3 = '0;
  logic [2:0]   rdy3;
  logic [31:0]  gd3;
  logic         gv3, sof3, eof3, busy3, err3;
  logic [1:0]   own3;

  enc_src_arbiter #(.ARB_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_data(d4), .req_ready(rdy4),
    .con_stall(stall), .gen_data(gd4), .gen_valid(gv4), .arb_sof(sof4),
    .arb_eof(eof4), .arb_owner(own4), .arb_busy(busy4), .arb_err(err4));

  enc_src_arbiter #(.ARB_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
    .con_stall(stall), .gen_data(gd3), .gen_valid(gv3), .arb_sof(sof3),
    .arb_eof(eof3), .arb_owner(own3), .arb_busy(busy3), .arb_err(err3));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int seq4[4];
  int seq3[3];
  model_t m4, m3;
  beat_t q4[$];
  beat_t q3[$];
  int err4_n, err4_cyc, eof4_n, sof4_n, sof3_n, own3_max;
  bit err4_busy;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic model_t mreset(int n);
    model_t r;
    r = '0;
    r.n = n;
    return r;
  endfunction

  // Message-level rules: pick next valid requester round-robin, hand over after MB
  // beats or TO idle cycles; outputs describe what the next cycle must show.
  function automatic model_t mstep(model_t m, logic [7:0] v, logic s, logic [255:0] d);
    model_t r;
    bit found;
    r = m;
    r.gv = 1'b0; r.gd = '0; r.sof = 1'b0; r.eof = 1'b0; r.err = 1'b0;
    found = 1'b0;
    if (!m.busy) begin
      for (int k = 0; k < m.n; k++) begin
        if (!found && v[(m.ptr + k) % m.n]) begin
          found = 1'b1;
          r.owner = (m.ptr + k) % m.n;
          r.busy = 1'b1;
        end
      end
    end else if (!s) begin
      if (v[m.owner]) begin
        r.gv = 1'b1;
        r.gd = d[m.owner*32 +: 32];
        r.sof = (m.beats == 0);
        r.eof = (m.beats == MB - 1);
        r.idle = 0;
        if (m.beats == MB - 1) begin
          r.busy = 1'b0; r.beats = 0; r.ptr = (m.owner + 1) % m.n;
        end else begin
          r.beats = m.beats + 1;
        end
      end else begin
        r.idle = m.idle + 1;
        if (r.idle == TO) begin
          r.err = 1'b1; r.busy = 1'b0; r.beats = 0; r.idle = 0;
          r.ptr = (m.owner + 1) % m.n;
        end
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    logic [3:0] er4;
    logic [2:0] er3;
    beat_t b;
    er4 = (m4.busy && !stall) ? (4'b0001 << m4.owner) : 4'b0000;
    er3 = (m3.busy && !stall) ? (3'b001 << m3.owner) : 3'b000;
    check("dut4_ctrl", {rdy4, gv4, sof4, eof4, err4, busy4, own4},
          {er4, m4.gv, m4.sof, m4.eof, m4.err, m4.busy, 2'(m4.owner)});
    check("dut4_data", {32'd0, gd4}, {32'd0, m4.gd});
    check("dut3_ctrl", {rdy3, gv3, sof3, eof3, err3, busy3, own3},
          {er3, m3.gv, m3.sof, m3.eof, m3.err, m3.busy, 2'(m3.owner)});
    check("dut3_data", {32'd0, gd3}, {32'd0, m3.gd});
    if (gv4) begin
      b.cyc = cyc; b.d = gd4; b.sof = sof4; b.eof = eof4;
      q4.push_back(b);
    end
    if (gv3) begin
      b.cyc = cyc; b.d = gd3; b.sof = sof3; b.eof = eof3;
      q3.push_back(b);
    end
    if (sof4) sof4_n++;
    if (eof4) eof4_n++;
    if (err4) begin
      err4_n++; err4_cyc = cyc; err4_busy = busy4;
    end
    if (sof3) sof3_n++;
    if (int'(own3) > own3_max) own3_max = int'(own3);
  endtask

  task automatic half_a();
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = {8'(i), 24'(seq4[i])};
    for (int i = 0; i < 3; i++) d3[i*32 +: 32] = {8'(i), 24'(seq3[i])};
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic half_b();
    @(posedge clk);
    if (m4.busy && !stall && v4[m4.owner]) seq4[m4.owner]++;
    if (m3.busy && !stall && v3[m3.owner]) seq3[m3.owner]++;
    m4 = mstep(m4, 8'(v4), stall, 256'(d4));
    m3 = mstep(m3, 8'(v3), stall, 256'(d3));
    #1;
  endtask

  task automatic cycle();
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m4 = mreset(4);
    m3 = mreset(3);
    for (int i = 0; i < 4; i++) seq4[i] = 0;
    for (int i = 0; i < 3; i++) seq3[i] = 0;
    #2;
    check("rst_dut4", {rdy4, gv4, sof4, eof4, err4, busy4, own4, gd4}, 64'd0);
    check("rst_dut3", {rdy3, gv3, sof3, eof3, err3, busy3, own3, gd3}, 64'd0);
    q4.delete(); q3.delete();
    err4_n = 0; eof4_n = 0; sof4_n = 0; sof3_n = 0; own3_max = 0; err4_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int good;
    int rdy_bad, gv_bad;
    int ids[$];
    tbl[0] = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[2] = '{4'b0110, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[3] = '{4'b0110, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[4] = '{4'b0100, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1};
    tbl[5] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[6] = '{4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1};

    #1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      v4 = tbl[i].v;
      stall = tbl[i].s;
      half_a();
      check("tbl", {rdy4, gv4, sof4, busy4, own4},
            {tbl[i].rdy, tbl[i].gv, tbl[i].sof, tbl[i].busy, tbl[i].own});
      half_b();
    end
    stall = 1'b0;

    // Requester 2 alone: one full message, then regrant after one bubble.
    do_reset();
    v4 = 4'b0100;
    for (int t = 0; t < 200 && q4.size() < MB + 1; t++) cycle();
    check("s1_beats", q4.size(), MB + 1);
    if (q4.size() >= MB + 1) begin
      good = 0;
      for (int k = 0; k < MB; k++)
        if (q4[k].d == {8'd2, 24'(k)} && q4[k].sof == (k == 0) && q4[k].eof == (k == MB - 1))
          good++;
      check("s1_order", good, MB);
      check("s1_regrant", {q4[MB].d, q4[MB].sof}, {8'd2, 24'(MB), 1'b1});
      check("s1_gap", q4[MB].cyc - q4[MB-1].cyc, 2);
    end

    // All four requesters: grant order 0,1,2,3,0.
    do_reset();
    v4 = 4'b1111;
    for (int t = 0; t < 400 && sof4_n < 5; t++) cycle();
    check("s2_sofs", sof4_n, 5);
    if (q4.size() >= 4 * MB + 1) begin
      good = 0;
      for (int k = 0; k < 4 * MB; k++)
        if (q4[k].d == {8'(k / MB), 24'(k % MB)} && q4[k].sof == (k % MB == 0) &&
            q4[k].eof == (k % MB == MB - 1))
          good++;
      check("s2_msgs", good, 4 * MB);
      check("s2_wrap", {q4[4*MB].d, q4[4*MB].sof}, {8'd0, 24'(MB), 1'b1});
      good = 0;
      for (int m = 1; m <= 4; m++)
        if (q4[m*MB].cyc - q4[m*MB-1].cyc == 2) good++;
      check("s2_handover", good, 4);
    end

    // Owner 1 stalled for 10 cycles at beat 20.
    do_reset();
    v4 = 4'b0010;
    for (int t = 0; t < 200 && !(m4.busy && m4.beats == 20); t++) cycle();
    check("s3_pre", q4.size(), 19);
    stall = 1'b1;
    rdy_bad = 0; gv_bad = 0;
    for (int s = 0; s < 10; s++) begin
      half_a();
      if (rdy4[1]) rdy_bad++;
      if (s > 0 && gv4) gv_bad++;
      half_b();
    end
    stall = 1'b0;
    check("s3_stall_ready", rdy_bad, 0);
    check("s3_stall_gv", gv_bad, 0);
    for (int t = 0; t < 200 && eof4_n == 0; t++) cycle();
    check("s3_len", q4.size(), MB);
    if (q4.size() >= 21) begin
      check("s3_resume", q4[20].d, {8'd1, 24'd20});
      check("s3_resume_gap", q4[20].cyc - q4[19].cyc, 11);
    end
    check("s3_err", err4_n, 0);

    // Owner 3 goes silent after beat 5: timeout abort.
    do_reset();
    v4 = 4'b1000;
    for (int t = 0; t < 100 && !(m4.busy && m4.beats == 6); t++) cycle();
    v4 = 4'b0000;
    for (int t = 0; t < 400 && err4_n == 0; t++) cycle();
    check("s4_err_seen", err4_n, 1);
    if (q4.size() >= 6) check("s4_err_delay", err4_cyc - q4[5].cyc, TO);
    check("s4_busy_at_err", err4_busy, 0);
    v4 = 4'b1001;
    for (int t = 0; t < 20 && q4.size() < 7; t++) cycle();
    if (q4.size() >= 7) check("s4_regrant", {q4[6].d, q4[6].sof}, {8'd0, 24'd0, 1'b1});
    else check("s4_regrant_size", q4.size(), 7);
    for (int t = 0; t < 5; t++) cycle();
    check("s4_single_err", err4_n, 1);
    check("s4_no_eof", eof4_n, 0);

    // Reset at beat 30 of owner 0, then 1 and 3 request.
    do_reset();
    v4 = 4'b0001;
    for (int t = 0; t < 100 && !(m4.busy && m4.beats == 30); t++) cycle();
    check("s5_pre", q4.size(), 29);
    v4 = 4'b1010;
    do_reset();
    for (int t = 0; t < 20 && q4.size() < 1; t++) cycle();
    if (q4.size() >= 1) check("s5_first", {q4[0].d, q4[0].sof}, {8'd1, 24'd0, 1'b1});
    else check("s5_first_size", q4.size(), 1);
    check("s5_no_eof_err", {eof4_n, err4_n}, 64'd0);

    // Three requesters, 0 and 2 valid.
    do_reset();
    v4 = 4'b0000;
    v3 = 3'b101;
    for (int t = 0; t < 400 && sof3_n < 4; t++) cycle();
    ids.delete();
    foreach (q3[k]) if (q3[k].sof) ids.push_back(int'(q3[k].d[31:24]));
    good = 0;
    for (int k = 0; k < 4 && k < ids.size(); k++)
      if (ids[k] == ((k % 2 == 0) ? 0 : 2)) good++;
    check("s6_order", good, 4);
    check("s6_owner_max", own3_max, 2);

    // Randomized traffic on both instances.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) v4[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) v3[i] = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end
    stall = 1'b0;
    v4 = '0;
    v3 = '0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
